// File: rtl/veritune_pkg.sv
// Shared definitions for the Veritune playback path: controller state
// encoding and fixed-point constants.
package veritune_pkg;
  localparam int         FRAC_W     = 4;
  localparam logic [7:0] FREQ_UNITY = 8'h10;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_WAIT = 5'b00010,
    S_RDA  = 5'b00100,
    S_RDB  = 5'b01000,
    S_CALC = 5'b10000
  } state_t;
endpackage

// File: rtl/veritune_interp.sv
// Combinational linear interpolation between two adjacent samples at
// fractional position f (units of 1/2^FRAC_W).
module veritune_interp #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 4
) (
  input  logic signed [DATA_W-1:0] s0,
  input  logic signed [DATA_W-1:0] s1,
  input  logic        [FRAC_W-1:0] f,
  output logic signed [DATA_W-1:0] y
);
  localparam int PW = DATA_W + FRAC_W + 1;

  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] delta;

  always_comb begin
    diff  = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
    prod  = $signed({{FRAC_W{diff[DATA_W]}}, diff}) * $signed({{(DATA_W+1){1'b0}}, f});
    // |delta| <= |s1 - s0|, so truncating to DATA_W keeps the result between s0 and s1
    delta = DATA_W'(prod >>> FRAC_W);
    y     = s0 + delta;
  end
endmodule

// File: rtl/veritune_player.sv
// Playback reader: streams the sample RAM out one sample per audio tick,
// resampled by a Q4.4 step with linear interpolation.
module veritune_player #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int FRAC_W = veritune_pkg::FRAC_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic [ADDR_W-1:0]        Length,
  input  logic [7:0]               Freq,
  input  logic                     Loop,
  input  logic                     Sample_Tick,
  output logic                     Rd_En,
  output logic [ADDR_W-1:0]        Rd_Addr,
  input  logic signed [DATA_W-1:0] Rd_Data,
  output logic signed [DATA_W-1:0] Audio_Out,
  output logic                     Audio_Valid,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Tick_Miss
);
  import veritune_pkg::*;

  localparam int PH_W = ADDR_W + FRAC_W + 1;

  state_t                   state, state_nxt;
  logic [PH_W-1:0]          phase, phase_nxt, p, p_wrap;
  logic [ADDR_W-1:0]        len, len_nxt, rd_addr_nxt;
  logic [7:0]               step, step_nxt;
  logic                     loop, loop_nxt;
  logic signed [DATA_W-1:0] s0, s0_nxt, out_nxt, lerp;
  logic                     valid_nxt, done_nxt, miss_nxt, rd_en_nxt;
  logic [ADDR_W:0]          n, n_inc, len_x;

  assign n     = phase[PH_W-1:FRAC_W];
  assign n_inc = n + 1'b1;
  assign len_x = {1'b0, len};
  assign Busy  = (state != S_IDLE);

  veritune_interp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_interp (
    .s0 (s0),
    .s1 (Rd_Data),
    .f  (phase[FRAC_W-1:0]),
    .y  (lerp)
  );

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    len_nxt     = len;
    step_nxt    = step;
    loop_nxt    = loop;
    s0_nxt      = s0;
    out_nxt     = Audio_Out;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = Rd_Addr;
    miss_nxt    = Sample_Tick && (state inside {S_RDA, S_RDB, S_CALC});
    p           = phase + PH_W'(step);
    p_wrap      = p - {len_x + 1'b1, {FRAC_W{1'b0}}};
    case (state)
      S_IDLE: if (Start) begin
        len_nxt   = Length;
        step_nxt  = (Freq == 8'h00) ? FREQ_UNITY : Freq;
        loop_nxt  = Loop;
        phase_nxt = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (Sample_Tick) begin
        rd_en_nxt   = 1'b1;
        rd_addr_nxt = n[ADDR_W-1:0];
        state_nxt   = S_RDA;
      end
      S_RDA: begin
        // Right-hand neighbour, clamped so the last sample interpolates with itself
        rd_en_nxt   = 1'b1;
        rd_addr_nxt = (n_inc > len_x) ? len : n_inc[ADDR_W-1:0];
        state_nxt   = S_RDB;
      end
      S_RDB: begin
        s0_nxt    = Rd_Data;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        out_nxt   = lerp;
        valid_nxt = 1'b1;
        if (p[PH_W-1:FRAC_W] <= len_x) begin
          phase_nxt = p;
          state_nxt = S_WAIT;
        end else if (loop) begin
          // A step larger than the whole buffer restarts from the top
          phase_nxt = (p_wrap[PH_W-1:FRAC_W] > len_x) ? '0 : p_wrap;
          state_nxt = S_WAIT;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Stop) begin
      state_nxt = S_IDLE;
      out_nxt   = '0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      rd_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      len         <= '0;
      step        <= FREQ_UNITY;
      loop        <= 1'b0;
      s0          <= '0;
      Audio_Out   <= '0;
      Audio_Valid <= 1'b0;
      Done        <= 1'b0;
      Tick_Miss   <= 1'b0;
      Rd_En       <= 1'b0;
      Rd_Addr     <= '0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      len         <= len_nxt;
      step        <= step_nxt;
      loop        <= loop_nxt;
      s0          <= s0_nxt;
      Audio_Out   <= out_nxt;
      Audio_Valid <= valid_nxt;
      Done        <= done_nxt;
      Tick_Miss   <= miss_nxt;
      Rd_En       <= rd_en_nxt;
      Rd_Addr     <= rd_addr_nxt;
    end
  end
endmodule

// File: doc/veritune_player.md
# veritune_player

Playback reader for the Veritune audio path. It streams a recorded sample buffer back out as 16-bit audio, one sample per audio-rate tick. It reads the sample RAM that the record path filled, and resamples on the fly with a Q4.4 step (pitch shift) and linear interpolation. It sits between the sample RAM read port and the audio output driver, and is commanded by the top-level Veritune state machine when it enters PLAY.

## Interface

Parameters:
- ADDR_W, 17, sample RAM address width
- DATA_W, 16, signed sample width
- FRAC_W, 4, fractional bits of phase and step

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high
- Start  in  1  one-cycle pulse; begins playback from index 0
- Stop  in  1  abort; has priority over Start
- Length  in  ADDR_W  index of the last valid sample (recorded count − 1); latched on Start
- Freq  in  8  step, Q4.4 (0x10 = unity); latched on Start
- Loop  in  1  wrap at end instead of finishing; latched on Start
- Sample_Tick  in  1  one-cycle audio-rate strobe
- Rd_En  out  1  RAM read enable
- Rd_Addr  out  ADDR_W  RAM read address
- Rd_Data  in  DATA_W  RAM data, valid the cycle after Rd_En
- Audio_Out  out  DATA_W  signed output sample, registered
- Audio_Valid  out  1  one-cycle pulse when Audio_Out updates
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse at natural end of playback
- Tick_Miss  out  1  one-cycle pulse when a tick arrives outside WAIT

## Operation

- States: IDLE, WAIT, RDA, RDB, CALC.
- IDLE: on Start with no Stop: latch Length, Freq and Loop; clear phase; go to WAIT. Freq = 0 is latched as 0x10.
- WAIT: on Sample_Tick, go to RDA.
- Phase register is ADDR_W+FRAC_W+1 bits. n = phase integer part; f = phase[FRAC_W-1:0].
- RDA: Rd_En=1, Rd_Addr=n. Go to RDB.
- RDB: Rd_En=1, Rd_Addr=min(n+1, Length). Capture Rd_Data as s0. Go to CALC.
- CALC: s1 = Rd_Data.
  - Audio_Out ← s0 + ((s1 − s0)·f >>> FRAC_W).
  - Widths: the difference is 17-bit signed; the product is 21-bit signed; the shift is arithmetic. The result always lies between s0 and s1, so it needs no saturation.
  - Next phase p = phase + Freq.
  - If p's integer part ≤ Length: phase ← p; go to WAIT.
  - Otherwise, with Loop=1: p ← p − ((Length+1)<<FRAC_W). If p's integer part is still > Length, p ← 0. Store p in phase; go to WAIT.
  - Otherwise, with Loop=0: go to IDLE and pulse Done together with the final Audio_Valid.
- Stop in any state: go to IDLE on the next edge. Audio_Out ← 0. No Valid pulse and no Done pulse.
- Start while Busy is ignored.
- Sample_Tick in any state other than WAIT and IDLE is dropped, and Tick_Miss pulses.
- Length = 0 is legal: every output equals RAM[0].

## Timing

- Reset values: Audio_Out=0, Audio_Valid=0, Rd_En=0, Rd_Addr=0, Busy=0, Done=0, Tick_Miss=0; state=IDLE, phase=0.
- Rd_En and Rd_Addr are registered outputs, so they change on the edge that enters RDA or RDB.
- Tick sampled in WAIT at edge T:
  - RDA is active in cycle T+1 and RDB in T+2.
  - The sample is computed in CALC at T+3.
  - Audio_Out and Audio_Valid are visible from T+4.
- Tick-to-output latency is 4 cycles. Minimum tick spacing is 4 cycles.
- Busy rises the cycle after Start is sampled. It falls the cycle after the final CALC or the Stop.
- Reset mid-operation returns all outputs to their reset values immediately.

## Structure

- Shared package veritune_pkg holds:
  - the state encoding (one-hot, matching the rest of the design);
  - localparam FRAC_W = 4;
  - localparam FREQ_UNITY = 8'h10.
- Sub-module veritune_interp holds the combinational lerp. Inputs are s0, s1 and f; the output is a DATA_W sample. It is instanced once in CALC.

## Test plan

- Unity step: RAM=[100,200,300,400], Length=3, Freq=0x10, ticks every 8 cycles -> outputs 100,200,300,400; Done with the 4th Valid; Busy low the next cycle.
- Half step, same RAM, Freq=0x08 -> outputs 100,150,200,250,300,350,400,400; the 8th output uses s1 clamped to RAM[3]; then Done.
- Signed interpolation: RAM=[−1000,1000], Length=1, Freq=0x04 -> outputs −1000,−500,0,500,1000,1000,1000,1000; then Done.
- Loop: RAM=[10,20,30], Length=2, Freq=0x20, Loop=1 -> outputs 10,30,20,10,30,… with no Done. Stop -> Busy=0 and Audio_Out=0 one cycle later, no Valid pulse.
- Handshake edges:
  - ticks 2 cycles apart -> Tick_Miss pulses and the dropped tick produces no output;
  - Start while Busy -> ignored;
  - Start with Stop in the same cycle -> stays IDLE;
  - Freq=0 -> plays at unity.
- Reset asserted during RDB -> all outputs 0 immediately. A Start after release plays from index 0.
